bilstm_batch_sequencer: RTL

- Hardware replacement for the software batch loop around BiLSTM_TOP.
- Accepts a streamed input sequence and fills the BiLSTM input memory in fixed-size batches, pulsing start for each batch.
- Waits for concat-store completion, then drains the concat memory as a backpressured output stream.
- Generalised in batch count, batch size, output vector size and data width; repeats for a run-time number of batches.

---
 rtl/bilstm_batch_sequencer_if.sv | 43 ++++
 rtl/bilstm_batch_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bilstm_batch_sequencer_if.sv
// Handshake and memory-port bundle for bilstm_batch_sequencer.
// master = the sequencer itself, slave = surrounding BiLSTM / stream logic.
interface bilstm_batch_sequencer_if #(
    parameter int DATA_WIDTH       = 16,
    parameter int INPUT_ADDR_WIDTH = 6,
    parameter int OUT_ADDR_WIDTH   = 8,
    parameter int BATCH_CNT_W      = 8
);
    logic                        run;
    logic [BATCH_CNT_W-1:0]      num_batches;
    logic [DATA_WIDTH-1:0]       in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic                        lstm_wr_en;
    logic [INPUT_ADDR_WIDTH-1:0] lstm_wr_addr;
    logic [DATA_WIDTH-1:0]       lstm_wr_data;
    logic                        lstm_start;
    logic                        lstm_done;
    logic                        concat_rd_en;
    logic [OUT_ADDR_WIDTH-1:0]   concat_rd_addr;
    logic [DATA_WIDTH-1:0]       concat_rd_data;
    logic [DATA_WIDTH-1:0]       out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;
    logic [BATCH_CNT_W-1:0]      batch_idx;
    logic                        busy;
    logic                        all_done;

    modport master (
        input  run, num_batches, in_data, in_valid, lstm_done, concat_rd_data, out_ready,
        output in_ready, lstm_wr_en, lstm_wr_addr, lstm_wr_data, lstm_start,
               concat_rd_en, concat_rd_addr, out_data, out_valid, out_last,
               batch_idx, busy, all_done
    );

    modport slave (
        output run, num_batches, in_data, in_valid, lstm_done, concat_rd_data, out_ready,
        input  in_ready, lstm_wr_en, lstm_wr_addr, lstm_wr_data, lstm_start,
               concat_rd_en, concat_rd_addr, out_data, out_valid, out_last,
               batch_idx, busy, all_done
    );
endinterface

// File: rtl/bilstm_batch_sequencer.sv
// Batch sequencer around BiLSTM_TOP: loads input batches, pulses start,
// waits for the concat store to finish and drains the concat memory as a
// backpressured stream. Optional WAIT watchdog: BILSTM_SEQ_TIMEOUT_EN.
module bilstm_batch_sequencer #(
    parameter int DATA_WIDTH       = 16,
    parameter int ELEMS_PER_BATCH  = 60,
    parameter int INPUT_ADDR_WIDTH = 6,
    parameter int VEC_SIZE         = 200,
    parameter int OUT_ADDR_WIDTH   = 8,
    parameter int BATCH_CNT_W      = 8,
    parameter int TIMEOUT_CYCLES   = 65535
) (
    input  logic clk,
    input  logic rst,
    bilstm_batch_sequencer_if.master bus
`ifdef BILSTM_SEQ_TIMEOUT_EN
    ,
    output logic timeout_err
`endif
);
    localparam int RD_W = OUT_ADDR_WIDTH + 1;

    if (ELEMS_PER_BATCH > 2 ** INPUT_ADDR_WIDTH || VEC_SIZE > 2 ** OUT_ADDR_WIDTH ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("bilstm_batch_sequencer: inconsistent parameters");
    end

`ifdef BILSTM_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN, S_NEXT, S_ERROR} state_t;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN, S_NEXT} state_t;
`endif

    state_t                      state, state_nxt;
    logic [INPUT_ADDR_WIDTH-1:0] elem_cnt;
    logic [RD_W-1:0]             rd_cnt;
    logic [BATCH_CNT_W-1:0]      batch_idx_q, last_idx;
    logic                        done_prev;
    logic                        rd_inflight, rd_last_q;
    logic [DATA_WIDTH-1:0]       fifo_data [2];
    logic [1:0]                  fifo_last;
    logic                        wr_ptr, rd_ptr;
    logic [1:0]                  fifo_cnt, occ_after;
    logic                        beat, last_beat, pop, rd_issue, last_acc, head_last;

    assign beat      = (state == S_LOAD) && bus.in_valid;
    assign last_beat = beat && (elem_cnt == INPUT_ADDR_WIDTH'(ELEMS_PER_BATCH - 1));
    assign head_last = fifo_last[rd_ptr];
    assign pop       = (fifo_cnt != 2'd0) && bus.out_ready;
    assign last_acc  = pop && head_last;
    // Occupancy is taken after this cycle's pop, which is what lets a read
    // issue every cycle while the consumer keeps out_ready high.
    assign occ_after = fifo_cnt - {1'b0, pop};
    assign rd_issue  = (state == S_DRAIN) && (rd_cnt < RD_W'(VEC_SIZE)) &&
                       ((occ_after + {1'b0, rd_inflight}) < 2'd2);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt           = state;
        bus.in_ready        = 1'b0;
        bus.lstm_start      = 1'b0;
        bus.all_done        = 1'b0;
        bus.busy            = (state != S_IDLE);
        bus.batch_idx       = batch_idx_q;
        bus.lstm_wr_en      = beat;
        bus.lstm_wr_addr    = beat ? elem_cnt : '0;
        bus.lstm_wr_data    = beat ? bus.in_data : '0;
        bus.concat_rd_en    = rd_issue;
        bus.concat_rd_addr  = rd_issue ? rd_cnt[OUT_ADDR_WIDTH-1:0] : '0;
        bus.out_valid       = (fifo_cnt != 2'd0);
        bus.out_data        = (fifo_cnt != 2'd0) ? fifo_data[rd_ptr] : '0;
        bus.out_last        = (fifo_cnt != 2'd0) && head_last;
        case (state)
            S_IDLE:  if (bus.run) state_nxt = S_LOAD;
            S_LOAD: begin
                bus.in_ready = 1'b1;
                if (last_beat) state_nxt = S_START;
            end
            S_START: begin
                bus.lstm_start = 1'b1;
                state_nxt      = S_WAIT;
            end
            S_WAIT: begin
                if (bus.lstm_done && !done_prev) state_nxt = S_DRAIN;
`ifdef BILSTM_SEQ_TIMEOUT_EN
                else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) state_nxt = S_ERROR;
`endif
            end
            S_DRAIN: if (last_acc) state_nxt = S_NEXT;
            S_NEXT: begin
                if (batch_idx_q == last_idx) begin
                    bus.all_done = 1'b1;
                    state_nxt    = S_IDLE;
                end else begin
                    state_nxt = S_LOAD;
                end
            end
`ifdef BILSTM_SEQ_TIMEOUT_EN
            S_ERROR: state_nxt = S_ERROR;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Run bookkeeping, element/read counters and done edge tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            elem_cnt    <= '0;
            rd_cnt      <= '0;
            batch_idx_q <= '0;
            last_idx    <= '0;
            done_prev   <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.run) begin
                last_idx    <= (bus.num_batches == '0) ? '0 : bus.num_batches - BATCH_CNT_W'(1);
                batch_idx_q <= '0;
            end
            if (state == S_NEXT && batch_idx_q != last_idx) batch_idx_q <= batch_idx_q + BATCH_CNT_W'(1);
            if (beat) elem_cnt <= last_beat ? '0 : elem_cnt + INPUT_ADDR_WIDTH'(1);
            // Held high outside WAIT, so a done level left over from the
            // previous batch must drop before it can rise again.
            done_prev <= (state == S_WAIT) ? bus.lstm_done : 1'b1;
            if (rd_issue)              rd_cnt <= rd_cnt + RD_W'(1);
            else if (state != S_DRAIN) rd_cnt <= '0;
        end
    end

    // Two-entry output FIFO fed by reads returning one cycle after issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_inflight  <= 1'b0;
            rd_last_q    <= 1'b0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_cnt     <= 2'd0;
            fifo_last    <= 2'b00;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
        end else begin
            rd_inflight <= rd_issue;
            rd_last_q   <= rd_issue && (rd_cnt == RD_W'(VEC_SIZE - 1));
            if (rd_inflight) begin
                fifo_data[wr_ptr] <= bus.concat_rd_data;
                fifo_last[wr_ptr] <= rd_last_q;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, rd_inflight} - {1'b0, pop};
        end
    end

`ifdef BILSTM_SEQ_TIMEOUT_EN
    // WAIT watchdog; the error flag stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt <= (state == S_WAIT) ? wait_cnt + TW'(1) : '0;
            if (state == S_WAIT && state_nxt == S_ERROR) timeout_err <= 1'b1;
        end
    end
`endif
endmodule
